pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 core. It sits beside the F/D/E/M/W pipeline registers and drives their per-stage stall and bubble controls. The controls cover load/use hazards, `ret` processing, mispredicted `jXX` and exception drain, plus gating of the condition-code write. A run-state machine sequences core start, run and halt, and free-running performance counters report cycles, stalls, flushes and retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  leave IDLE and begin execution
- clear_i  in  1  leave HALT and return to IDLE
- D_icode_i  in  4  icode held in D register
- d_srcA_i, d_srcB_i  in  4  decode source register IDs (`RNONE` = 4'hF)
- E_icode_i  in  4  icode in E register
- E_dstM_i  in  4  memory destination register in E
- e_Cnd_i  in  1  branch condition from execute
- M_icode_i  in  4  icode in M register
- m_stat_i  in  4  status produced by memory stage
- W_icode_i  in  4  icode in W register
- W_stat_i  in  4  status in W register
- F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o  out  1 each  pipeline register controls
- set_cc_o  out  1  condition-code write enable
- state_o  out  2  run state (IDLE=0, RUN=1, HALT=2)
- stat_o  out  4  latched final status
- cycle_cnt_o, stall_cnt_o, flush_cnt_o, retire_cnt_o  out  CNT_W each  performance counters

## Operation
Hazard terms (combinational):
- lu = E_icode ∈ {IMRMOVQ, IPOPQ} && E_dstM != RNONE && E_dstM ∈ {d_srcA, d_srcB}
- rt = IRET ∈ {D_icode, E_icode, M_icode}
- mp = E_icode == IJXX && !e_Cnd
- exc = m_stat ∈ {SADR, SINS, SHLT} || W_stat ∈ {SADR, SINS, SHLT}

IDLE state:
- F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1; all other controls 0; set_cc=0.
- The pipeline fills with bubbles.
- start_i → RUN.

RUN state:
- F_stall = lu | rt
- D_stall = lu
- D_bubble = mp | (rt & !lu)
- E_bubble = mp | lu
- M_bubble = exc
- W_stall = W_stat ∉ {SAOK}
- set_cc = E_icode==IOPQ & !exc
- When W_stat_i ∉ {SAOK} → HALT, and W_stat_i is latched into stat_o on the same edge.

HALT state:
- F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1, W_stall=1, set_cc=0.
- clear_i → IDLE, and stat_o returns to SAOK.
- start_i is ignored in HALT.

Priority and boundary rules:
- D_stall and D_bubble are never both 1. lu+rt gives a stall with no D bubble.
- mp and lu are mutually exclusive because E holds a single icode.
- start_i and clear_i are each honoured only in their own state.

Counters (all in RUN only; hold their value otherwise; wrap modulo 2^CNT_W):
- cycle_cnt increments every RUN cycle.
- stall_cnt increments on RUN cycles with lu.
- flush_cnt increments on RUN cycles with mp.
- retire_cnt increments when W_stall=0 and W_stat==SAOK and W_icode ∉ {INOP}.

## Timing
- Stall, bubble and set_cc outputs are combinational from inputs and the current state, so they take effect at the next clock edge (zero-cycle latency).
- state, stat_o and the counters are registered and update on the rising edge of clk_i.
- rst_i asynchronously forces: state=IDLE, stat_o=SAOK, all counters 0.
  - Control outputs then take their IDLE values: F_stall=D_bubble=E_bubble=M_bubble=1, others 0.
- Reset mid-RUN or mid-HALT aborts immediately to IDLE. No drain occurs.
- Load/use costs 1 stall cycle.
- `ret` costs 3 bubble cycles in D.
- Mispredict flushes D and E in 1 cycle.
- HALT is entered on the edge following the first cycle in which W_stat ≠ SAOK.

## Structure
- Shared constants stay in define.v: icodes, RNONE, RRSP, stat codes SAOK=1/SADR=2... per the existing encoding, and the new state encodings PC_IDLE/PC_RUN/PC_HALT.
- Sub-module pipe_hazard: purely combinational. It computes lu, rt, mp and exc.
- pipe_ctrl instantiates pipe_hazard and holds the FSM, the stat latch and the counters.

## Test plan
- Reset, then start_i pulse: state_o goes 0→1. All counters are 0 before start, and cycle_cnt reaches 5 after 5 RUN cycles.
- Load/use, with E_icode=IMRMOVQ, E_dstM=3, d_srcB=3 for one cycle:
  - outputs are F_stall=1, D_stall=1, E_bubble=1, D_bubble=0;
  - stall_cnt increments by 1.
- IRET walking D→E→M over 3 cycles: F_stall=1 and D_bubble=1 in each of those cycles.
- Mispredict, with E_icode=IJXX and e_Cnd=0: D_bubble=1, E_bubble=1, F_stall=0, and flush_cnt increments by 1.
- Exception drain, with m_stat=SADR for one cycle then W_stat=SADR:
  - M_bubble=1 and set_cc=0 when E_icode=IOPQ;
  - the next edge moves state to HALT with stat_o=SADR and W_stall=1;
  - clear_i returns state to IDLE with stat_o=SAOK.
- Asynchronous rst_i asserted mid-RUN with counters nonzero: all counters go to 0 and state goes to IDLE immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - Y86-64 encodings and run-state type shared by the pipeline control unit
package pipe_ctrl_pkg;

   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] RNONE   = 4'hF;

   localparam logic [3:0] SAOK    = 4'h1;
   localparam logic [3:0] SADR    = 4'h2;
   localparam logic [3:0] SINS    = 4'h3;
   localparam logic [3:0] SHLT    = 4'h4;

   typedef enum logic [1:0] {
      PC_IDLE = 2'd0,
      PC_RUN  = 2'd1,
      PC_HALT = 2'd2
   } pc_state_t;

   function automatic logic is_fault(input logic [3:0] stat);
      return (stat == SADR) || (stat == SINS) || (stat == SHLT);
   endfunction

endpackage

// File: rtl/pipe_hazard.sv
// rtl/pipe_hazard.sv - combinational hazard detection: load/use, ret, mispredict, exception
module pipe_hazard
   import pipe_ctrl_pkg::*;
(
   input  logic [3:0] d_icode,
   input  logic [3:0] d_src_a,
   input  logic [3:0] d_src_b,
   input  logic [3:0] e_icode,
   input  logic [3:0] e_dst_m,
   input  logic       e_cnd,
   input  logic [3:0] m_icode,
   input  logic [3:0] m_stat,
   input  logic [3:0] w_stat,
   output logic       lu,
   output logic       rt,
   output logic       mp,
   output logic       exc
);

   logic e_is_load;

   assign e_is_load = (e_icode == IMRMOVQ) || (e_icode == IPOPQ);
   assign lu  = e_is_load && (e_dst_m != RNONE) &&
                ((e_dst_m == d_src_a) || (e_dst_m == d_src_b));
   assign rt  = (d_icode == IRET) || (e_icode == IRET) || (m_icode == IRET);
   assign mp  = (e_icode == IJXX) && !e_cnd;
   assign exc = is_fault(m_stat) || is_fault(w_stat);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/bubble control, run-state FSM, final status latch and perf counters
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             clear_i,
   input  logic [3:0]       D_icode_i,
   input  logic [3:0]       d_srcA_i,
   input  logic [3:0]       d_srcB_i,
   input  logic [3:0]       E_icode_i,
   input  logic [3:0]       E_dstM_i,
   input  logic             e_Cnd_i,
   input  logic [3:0]       M_icode_i,
   input  logic [3:0]       m_stat_i,
   input  logic [3:0]       W_icode_i,
   input  logic [3:0]       W_stat_i,
   output logic             F_stall_o,
   output logic             D_stall_o,
   output logic             D_bubble_o,
   output logic             E_bubble_o,
   output logic             M_bubble_o,
   output logic             W_stall_o,
   output logic             set_cc_o,
   output logic [1:0]       state_o,
   output logic [3:0]       stat_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic [CNT_W-1:0] retire_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   pc_state_t state, state_nxt;
   logic      lu, rt, mp, exc;
   logic      w_ok, in_run, retire;

   pipe_hazard u_hazard (
      .d_icode (D_icode_i),
      .d_src_a (d_srcA_i),
      .d_src_b (d_srcB_i),
      .e_icode (E_icode_i),
      .e_dst_m (E_dstM_i),
      .e_cnd   (e_Cnd_i),
      .m_icode (M_icode_i),
      .m_stat  (m_stat_i),
      .w_stat  (W_stat_i),
      .lu      (lu),
      .rt      (rt),
      .mp      (mp),
      .exc     (exc)
   );

   assign w_ok    = (W_stat_i == SAOK);
   assign in_run  = (state == PC_RUN);
   assign retire  = in_run && !W_stall_o && w_ok && (W_icode_i != INOP);
   assign state_o = state;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= PC_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      F_stall_o  = 1'b0;
      D_stall_o  = 1'b0;
      D_bubble_o = 1'b0;
      E_bubble_o = 1'b0;
      M_bubble_o = 1'b0;
      W_stall_o  = 1'b0;
      set_cc_o   = 1'b0;
      case (state)
         PC_IDLE: begin
            F_stall_o  = 1'b1;
            D_bubble_o = 1'b1;
            E_bubble_o = 1'b1;
            M_bubble_o = 1'b1;
            if (start_i) state_nxt = PC_RUN;
         end
         PC_RUN: begin
            // lu wins over rt in D: the stalled load-user must not be bubbled away
            F_stall_o  = lu | rt;
            D_stall_o  = lu;
            D_bubble_o = mp | (rt & ~lu);
            E_bubble_o = mp | lu;
            M_bubble_o = exc;
            W_stall_o  = ~w_ok;
            set_cc_o   = (E_icode_i == IOPQ) & ~exc;
            if (!w_ok) state_nxt = PC_HALT;
         end
         PC_HALT: begin
            F_stall_o  = 1'b1;
            D_bubble_o = 1'b1;
            E_bubble_o = 1'b1;
            M_bubble_o = 1'b1;
            W_stall_o  = 1'b1;
            if (clear_i) state_nxt = PC_IDLE;
         end
         default: state_nxt = PC_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stat_o <= SAOK;
      end else if (in_run && !w_ok) begin
         stat_o <= W_stat_i;
      end else if (state == PC_HALT && clear_i) begin
         stat_o <= SAOK;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cycle_cnt_o  <= '0;
         stall_cnt_o  <= '0;
         flush_cnt_o  <= '0;
         retire_cnt_o <= '0;
      end else if (in_run) begin
         cycle_cnt_o <= cycle_cnt_o + CNT_ONE;
         if (lu)     stall_cnt_o  <= stall_cnt_o + CNT_ONE;
         if (mp)     flush_cnt_o  <= flush_cnt_o + CNT_ONE;
         if (retire) retire_cnt_o <= retire_cnt_o + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl with a behavioural run-state/counter model
module tb_pipe_ctrl;

   localparam logic [3:0] INOP = 4'h1, IRRMOVQ = 4'h2, IMRMOVQ = 4'h5, IOPQ = 4'h6;
   localparam logic [3:0] IJXX = 4'h7, IRET = 4'h9, IPOPQ = 4'hB, IHALT = 4'h0;
   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] SAOK = 4'h1, SADR = 4'h2, SINS = 4'h3, SHLT = 4'h4;
   localparam logic [6:0] CTRL_IDLE = 7'b1011100;
   localparam logic [6:0] CTRL_HALT = 7'b1011110;

   logic clk = 1'b0;
   logic rst, start, clear, e_cnd;
   logic [3:0] d_icode, d_src_a, d_src_b, e_icode, e_dst_m, m_icode, m_stat, w_icode, w_stat;
   logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc;
   logic [1:0] state_o;
   logic [3:0] stat_o;
   logic [31:0] cycle_cnt, stall_cnt, flush_cnt, retire_cnt;
   logic [6:0] ctrl;

   int checks = 0;
   int errors = 0;

   // behavioural model: 0=IDLE 1=RUN 2=HALT
   logic [1:0]  m_state;
   logic [3:0]  m_stat_l;
   logic [31:0] m_cycle, m_stall, m_flush, m_retire;

   logic [3:0] icode_pool [8] = '{INOP, IOPQ, IMRMOVQ, IPOPQ, IJXX, IRET, IRRMOVQ, IHALT};
   logic [3:0] fault_pool [3] = '{SADR, SINS, SHLT};

   always #5 clk = ~clk;

   assign ctrl = {f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc};

   pipe_ctrl #(.CNT_W(32)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
      .D_icode_i(d_icode), .d_srcA_i(d_src_a), .d_srcB_i(d_src_b),
      .E_icode_i(e_icode), .E_dstM_i(e_dst_m), .e_Cnd_i(e_cnd),
      .M_icode_i(m_icode), .m_stat_i(m_stat), .W_icode_i(w_icode), .W_stat_i(w_stat),
      .F_stall_o(f_stall), .D_stall_o(d_stall), .D_bubble_o(d_bubble), .E_bubble_o(e_bubble),
      .M_bubble_o(m_bubble), .W_stall_o(w_stall), .set_cc_o(set_cc),
      .state_o(state_o), .stat_o(stat_o),
      .cycle_cnt_o(cycle_cnt), .stall_cnt_o(stall_cnt),
      .flush_cnt_o(flush_cnt), .retire_cnt_o(retire_cnt)
   );

   function automatic bit bad_stat(input logic [3:0] s);
      return (s == SADR) || (s == SINS) || (s == SHLT);
   endfunction

   function automatic bit f_lu();
      return ((e_icode == IMRMOVQ) || (e_icode == IPOPQ)) && (e_dst_m != RNONE) &&
             ((e_dst_m == d_src_a) || (e_dst_m == d_src_b));
   endfunction

   function automatic bit f_mp();
      return (e_icode == IJXX) && !e_cnd;
   endfunction

   function automatic logic [6:0] exp_ctrl();
      bit lu, rt, mp, exc;
      lu  = f_lu();
      mp  = f_mp();
      rt  = (d_icode == IRET) || (e_icode == IRET) || (m_icode == IRET);
      exc = bad_stat(m_stat) || bad_stat(w_stat);
      if (m_state == 2'd0) return CTRL_IDLE;
      if (m_state == 2'd2) return CTRL_HALT;
      return {lu | rt, lu, mp | (rt & !lu), mp | lu, exc, w_stat != SAOK, (e_icode == IOPQ) && !exc};
   endfunction

   task automatic model_reset();
      m_state = 2'd0; m_stat_l = SAOK;
      m_cycle = 0; m_stall = 0; m_flush = 0; m_retire = 0;
   endtask

   task automatic model_edge();
      case (m_state)
         2'd0: if (start) m_state = 2'd1;
         2'd1: begin
            m_cycle++;
            if (f_lu()) m_stall++;
            if (f_mp()) m_flush++;
            if (w_stat == SAOK && w_icode != INOP) m_retire++;
            if (w_stat != SAOK) begin m_state = 2'd2; m_stat_l = w_stat; end
         end
         default: if (clear) begin m_state = 2'd0; m_stat_l = SAOK; end
      endcase
   endtask

   task automatic benign();
      start = 0; clear = 0; e_cnd = 1;
      d_icode = INOP; d_src_a = RNONE; d_src_b = RNONE;
      e_icode = INOP; e_dst_m = RNONE; m_icode = INOP;
      m_stat = SAOK; w_icode = INOP; w_stat = SAOK;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      benign();
      rst = 1;
      model_reset();
      @(posedge clk); #1;
      rst = 0;
      #1;
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
      checks++; if (stat_o !== SAOK) begin errors++; $display("FAIL reset_stat: got %0d expected %0d", stat_o, SAOK); end
      checks++; if ({cycle_cnt, stall_cnt, flush_cnt, retire_cnt} !== 128'd0) begin
         errors++; $display("FAIL reset_counters: got %0d/%0d/%0d/%0d expected all 0", cycle_cnt, stall_cnt, flush_cnt, retire_cnt); end
      checks++; if (ctrl !== CTRL_IDLE) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, CTRL_IDLE); end
      clear = 1;
      tick();
      clear = 0;
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL clear_in_idle: got %0d expected 0", state_o); end
   endtask

   task automatic test_start();
      benign();
      tick();
      checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL idle_cycle_hold: got %0d expected 0", cycle_cnt); end
      start = 1;
      tick();
      start = 0;
      checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL start_state: got %0d expected 1", state_o); end
      checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL start_cycle: got %0d expected 0", cycle_cnt); end
      repeat (5) tick();
      checks++; if (cycle_cnt !== 32'd5) begin errors++; $display("FAIL run_cycle5: got %0d expected 5", cycle_cnt); end
   endtask

   task automatic test_load_use();
      benign();
      e_icode = IMRMOVQ; e_dst_m = 4'd3; d_src_b = 4'd3;
      #1;
      checks++; if (ctrl !== 7'b1101000) begin errors++; $display("FAIL load_use_ctrl: got %b expected 1101000", ctrl); end
      tick();
      checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt); end
      benign();
      e_icode = IPOPQ; e_dst_m = 4'd2; d_src_a = 4'd2; d_icode = IRET;
      #1;
      checks++; if (ctrl !== 7'b1101000) begin errors++; $display("FAIL lu_plus_ret_ctrl: got %b expected 1101000", ctrl); end
      tick();
      benign();
      e_icode = IMRMOVQ;
      #1;
      checks++; if (ctrl !== 7'b0000000) begin errors++; $display("FAIL lu_rnone_ctrl: got %b expected 0000000", ctrl); end
      tick();
      checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL lu_cnt2: got %0d expected 2", stall_cnt); end
   endtask

   task automatic test_ret();
      for (int s = 0; s < 3; s++) begin
         benign();
         if (s == 0) d_icode = IRET;
         if (s == 1) e_icode = IRET;
         if (s == 2) m_icode = IRET;
         #1;
         checks++; if (ctrl !== 7'b1010000) begin errors++; $display("FAIL ret_stage%0d: got %b expected 1010000", s, ctrl); end
         tick();
      end
      benign();
      #1;
      checks++; if (ctrl !== 7'b0000000) begin errors++; $display("FAIL ret_done: got %b expected 0000000", ctrl); end
   endtask

   task automatic test_mispredict();
      benign();
      e_icode = IJXX; e_cnd = 0;
      #1;
      checks++; if (ctrl !== 7'b0011000) begin errors++; $display("FAIL mispredict_ctrl: got %b expected 0011000", ctrl); end
      tick();
      checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL mispredict_cnt: got %0d expected 1", flush_cnt); end
      e_cnd = 1;
      #1;
      checks++; if (ctrl !== 7'b0000000) begin errors++; $display("FAIL taken_ctrl: got %b expected 0000000", ctrl); end
      tick();
      checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL taken_cnt: got %0d expected 1", flush_cnt); end
   endtask

   task automatic test_retire();
      benign();
      e_icode = IOPQ;
      #1;
      checks++; if (ctrl !== 7'b0000001) begin errors++; $display("FAIL set_cc_ctrl: got %b expected 0000001", ctrl); end
      w_icode = IOPQ;
      repeat (4) tick();
      w_icode = INOP;
      repeat (2) tick();
      checks++; if (retire_cnt !== 32'd4) begin errors++; $display("FAIL retire_cnt: got %0d expected 4", retire_cnt); end
   endtask

   task automatic test_exception();
      benign();
      m_stat = SADR; e_icode = IOPQ;
      #1;
      checks++; if (ctrl !== 7'b0000100) begin errors++; $display("FAIL exc_m_ctrl: got %b expected 0000100", ctrl); end
      tick();
      benign();
      w_stat = SADR; w_icode = IMRMOVQ;
      #1;
      checks++; if (ctrl !== 7'b0000110) begin errors++; $display("FAIL exc_w_ctrl: got %b expected 0000110", ctrl); end
      checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL exc_still_run: got %0d expected 1", state_o); end
      tick();
      checks++; if (state_o !== 2'd2 || stat_o !== SADR) begin
         errors++; $display("FAIL halt_entry: got state %0d stat %0d expected state 2 stat %0d", state_o, stat_o, SADR); end
      checks++; if (ctrl !== CTRL_HALT) begin errors++; $display("FAIL halt_ctrl: got %b expected %b", ctrl, CTRL_HALT); end
      start = 1;
      tick();
      start = 0;
      checks++; if (state_o !== 2'd2 || cycle_cnt !== m_cycle) begin
         errors++; $display("FAIL halt_start_ignored: got state %0d cycles %0d expected state 2 cycles %0d", state_o, cycle_cnt, m_cycle); end
      clear = 1;
      tick();
      benign();
      checks++; if (state_o !== 2'd0 || stat_o !== SAOK) begin
         errors++; $display("FAIL clear_to_idle: got state %0d stat %0d expected state 0 stat %0d", state_o, stat_o, SAOK); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         start   = ($urandom_range(0, 3) == 0);
         clear   = ($urandom_range(0, 3) == 0);
         d_icode = icode_pool[$urandom_range(0, 7)];
         e_icode = icode_pool[$urandom_range(0, 7)];
         m_icode = icode_pool[$urandom_range(0, 7)];
         w_icode = icode_pool[$urandom_range(0, 7)];
         d_src_a = ($urandom_range(0, 4) == 0) ? RNONE : 4'($urandom_range(0, 3));
         d_src_b = ($urandom_range(0, 4) == 0) ? RNONE : 4'($urandom_range(0, 3));
         e_dst_m = ($urandom_range(0, 4) == 0) ? RNONE : 4'($urandom_range(0, 3));
         e_cnd   = 1'($urandom_range(0, 1));
         m_stat  = ($urandom_range(0, 7) == 0) ? fault_pool[$urandom_range(0, 2)] : SAOK;
         w_stat  = ($urandom_range(0, 19) == 0) ? fault_pool[$urandom_range(0, 2)] : SAOK;
         #1;
         checks++; if (ctrl !== exp_ctrl()) begin
            errors++; $display("FAIL rand_ctrl[%0d]: got %b expected %b", n, ctrl, exp_ctrl()); end
         tick();
         checks++; if (state_o !== m_state || stat_o !== m_stat_l) begin
            errors++; $display("FAIL rand_state[%0d]: got %0d/%0d expected %0d/%0d", n, state_o, stat_o, m_state, m_stat_l); end
         checks++; if ({cycle_cnt, stall_cnt, flush_cnt, retire_cnt} !== {m_cycle, m_stall, m_flush, m_retire}) begin
            errors++; $display("FAIL rand_cnt[%0d]: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", n,
               cycle_cnt, stall_cnt, flush_cnt, retire_cnt, m_cycle, m_stall, m_flush, m_retire); end
      end
   endtask

   task automatic test_async_reset();
      benign();
      clear = 1;
      tick();
      clear = 0; start = 1;
      tick();
      start = 0;
      w_icode = IOPQ; e_icode = IMRMOVQ; e_dst_m = 4'd1; d_src_a = 4'd1;
      repeat (3) tick();
      checks++; if (state_o !== 2'd1 || cycle_cnt !== m_cycle || stall_cnt !== m_stall || cycle_cnt == 32'd0) begin
         errors++; $display("FAIL pre_reset_run: got state %0d cycles %0d stalls %0d expected state 1 cycles %0d stalls %0d",
            state_o, cycle_cnt, stall_cnt, m_cycle, m_stall); end
      #2;
      rst = 1;
      #1;
      checks++; if (state_o !== 2'd0 || {cycle_cnt, stall_cnt, flush_cnt, retire_cnt} !== 128'd0) begin
         errors++; $display("FAIL async_reset: got state %0d counters %0d/%0d/%0d/%0d expected state 0 counters 0",
            state_o, cycle_cnt, stall_cnt, flush_cnt, retire_cnt); end
      checks++; if (ctrl !== CTRL_IDLE) begin errors++; $display("FAIL async_reset_ctrl: got %b expected %b", ctrl, CTRL_IDLE); end
      model_reset();
      @(negedge clk);
      rst = 0;
      benign();
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1;
      benign();
      model_reset();
      test_reset();
      test_start();
      test_load_use();
      test_ret();
      test_mispredict();
      test_retire();
      test_exception();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
